// File: rtl/uart_tx_arb.sv
// Two-requester (exec core / program loader) FIFO arbiter and start/data sequencer for uart_tx.
// Optional build macro UART_TX_ARB_LDR_PRIO_EN selects strict loader priority instead of round-robin.
module uart_tx_arb #(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       core_valid,
    input  logic [7:0] core_data,
    output logic       core_ready,
    input  logic       ldr_valid,
    input  logic [7:0] ldr_data,
    output logic       ldr_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       grant_ldr,
    output logic       busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LAUNCH,
        ST_DRAIN
    } state_t;

    state_t state, state_n;

    logic [7:0]    core_mem [DEPTH];
    logic [7:0]    ldr_mem  [DEPTH];
    logic [PW-1:0] core_wr, core_rd, ldr_wr, ldr_rd;
    logic [CW-1:0] core_cnt, ldr_cnt, core_cnt_n, ldr_cnt_n;
    logic          last_ldr;
    logic          core_ne, ldr_ne;
    logic          push_core, push_ldr;
    logic          pop_core, pop_ldr;
    logic          win_ldr;

    // Readiness is gated by rst so nothing is accepted while reset is held.
    assign core_ready = !rst && (core_cnt != CW'(DEPTH));
    assign ldr_ready  = !rst && (ldr_cnt  != CW'(DEPTH));
    assign push_core  = core_valid && core_ready;
    assign push_ldr   = ldr_valid  && ldr_ready;
    assign core_ne    = core_cnt != '0;
    assign ldr_ne     = ldr_cnt  != '0;

    // Next-state, arbitration and pop decisions.
    always_comb begin
        state_n  = state;
        pop_core = 1'b0;
        pop_ldr  = 1'b0;
        win_ldr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (core_ne || ldr_ne) begin
`ifdef UART_TX_ARB_LDR_PRIO_EN
                    win_ldr = ldr_ne;
`else
                    win_ldr = ldr_ne && (!core_ne || !last_ldr);
`endif
                    pop_core = !win_ldr;
                    pop_ldr  = win_ldr;
                    state_n  = ST_ISSUE;
                end
            end
            ST_ISSUE:  state_n = ST_LAUNCH;
            ST_LAUNCH: state_n = ST_DRAIN;
            ST_DRAIN: begin
                if (!tx_busy) begin
                    state_n = ST_IDLE;
                end
            end
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        core_cnt_n = core_cnt + CW'(push_core) - CW'(pop_core);
        ldr_cnt_n  = ldr_cnt  + CW'(push_ldr)  - CW'(pop_ldr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FIFO storage needs no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (push_core) begin
            core_mem[core_wr] <= core_data;
        end
        if (push_ldr) begin
            ldr_mem[ldr_wr] <= ldr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_wr   <= '0;
            core_rd   <= '0;
            ldr_wr    <= '0;
            ldr_rd    <= '0;
            core_cnt  <= '0;
            ldr_cnt   <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            grant_ldr <= 1'b0;
            last_ldr  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (push_core) core_wr <= core_wr + PW'(1);
            if (push_ldr)  ldr_wr  <= ldr_wr  + PW'(1);
            if (pop_core)  core_rd <= core_rd + PW'(1);
            if (pop_ldr)   ldr_rd  <= ldr_rd  + PW'(1);
            core_cnt <= core_cnt_n;
            ldr_cnt  <= ldr_cnt_n;
            tx_start <= (state_n == ST_ISSUE);
            // Head byte is latched only on the IDLE->ISSUE edge and held until the next grant.
            if (pop_core) begin
                tx_data   <= core_mem[core_rd];
                grant_ldr <= 1'b0;
                last_ldr  <= 1'b0;
            end else if (pop_ldr) begin
                tx_data   <= ldr_mem[ldr_rd];
                grant_ldr <= 1'b1;
                last_ldr  <= 1'b1;
            end
            busy <= (state_n != ST_IDLE) || (core_cnt_n != '0) || (ldr_cnt_n != '0);
        end
    end

endmodule
